instruction_fetch: RTL



---
 rtl/fetch_pkg.sv | 9 +
 rtl/pc_register.sv | 32 +++
 rtl/instruction_fetch.sv | 73 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the Armv4 instruction fetch stage.
package fetch_pkg;

  typedef enum logic {FETCH, HOLD} fetch_state_t;

  localparam int unsigned INSTRUCTION_BYTES = 4;
  localparam int unsigned PC_READ_OFFSET    = 8;

endpackage

// File: rtl/pc_register.sv
// Program counter flop with synchronous reset, enable and next-PC select
// (sequential PC+4 or a word-aligned branch target).
module pc_register
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pc_source,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] aligned_target;
  logic [WIDTH-1:0] next_pc;

  // Low address bits of a branch target are dropped so fetches stay word aligned.
  assign aligned_target = branch_target & ~WIDTH'(INSTRUCTION_BYTES - 1);
  assign next_pc        = pc_source ? aligned_target : pc + WIDTH'(INSTRUCTION_BYTES);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else if (enable) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: requests one word per instruction, holds it until the
// execute side accepts it, then steps the PC and the retired counter.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_request,
  output logic [WIDTH-1:0] imem_address,
  input  logic             imem_grant,
  input  logic [WIDTH-1:0] imem_read_data,
  output logic [WIDTH-1:0] instruction,
  output logic             instruction_valid,
  input  logic             instruction_accept,
  input  logic             pc_source,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_8,
  output logic [31:0]      retired_count
);

  fetch_state_t state;
  logic         accept;

  // Request is gated by reset so memory never sees a request during reset.
  assign imem_request = (state == FETCH) && !reset;
  assign imem_address = pc;
  assign pc_plus_8    = pc + WIDTH'(PC_READ_OFFSET);
  assign accept       = (state == HOLD) && instruction_accept;

  pc_register #(
    .WIDTH        (WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_register (
    .clock         (clock),
    .reset         (reset),
    .enable        (accept),
    .pc_source     (pc_source),
    .branch_target (branch_target),
    .pc            (pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= FETCH;
      instruction       <= '0;
      instruction_valid <= 1'b0;
      retired_count     <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_request && imem_grant) begin
            instruction       <= imem_read_data;
            instruction_valid <= 1'b1;
            state             <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            retired_count     <= retired_count + 32'd1;
            instruction_valid <= 1'b0;
            state             <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
